// File: rtl/sparc_window_regfile.sv
// Windowed SPARC V8 integer register file: 8 globals plus NWINDOWS overlapping
// 16-register windows, with CWP/WIM ownership and SAVE/RESTORE trap detection.
module sparc_window_regfile #(
    parameter int NWINDOWS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [4:0]          rd,
    input  logic [31:0]         wdata,
    input  logic                we,
    input  logic                save,
    input  logic                restore,
    input  logic                wim_we,
    input  logic [NWINDOWS-1:0] wim_din,
    output logic [31:0]         rdata1,
    output logic [31:0]         rdata2,
    output logic [4:0]          cwp,
    output logic [NWINDOWS-1:0] wim,
    output logic                trap_ovf,
    output logic                trap_unf
);
    localparam int WP_W  = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1;
    localparam int NPHYS = 8 + 16 * NWINDOWS;
    localparam int IDX_W = $clog2(NPHYS);
    localparam logic [NWINDOWS-1:0] WIM_RST = NWINDOWS'(2);
    localparam logic [WP_W-1:0]     WP_MAX  = WP_W'(NWINDOWS - 1);

    // Physical slots 0..7 are the globals (slot 0 never written), window w
    // starts at 8 + 16*w: outs then locals; its ins are the outs of w+1.
    logic [NPHYS-1:0][31:0] phys_q, phys_d;
    logic [WP_W-1:0]        cwp_q, cwp_d;
    logic [NWINDOWS-1:0]    wim_q, wim_d;
    logic                   trap_ovf_q, trap_ovf_d;
    logic                   trap_unf_q, trap_unf_d;

    logic [WP_W-1:0]  tgt_save, tgt_rest;
    logic             save_only, rest_only, ovf, unf, wr_en;
    logic [IDX_W-1:0] wr_idx;

    function automatic logic [IDX_W-1:0] phys_idx(input logic [4:0] r,
                                                  input logic [WP_W-1:0] w);
        int ri, wi, base;
        ri = int'(r);
        wi = int'(w);
        if (ri < 8)       base = ri;
        else if (ri < 24) base = 8 + 16 * wi + (ri - 8);
        else              base = 8 + 16 * ((wi + 1) % NWINDOWS) + (ri - 24);
        return IDX_W'(base);
    endfunction

    // Window movement and trap detection; a trap cancels the move and the write.
    always_comb begin
        tgt_save  = (cwp_q == '0) ? WP_MAX : cwp_q - 1'b1;
        tgt_rest  = (cwp_q == WP_MAX) ? '0 : cwp_q + 1'b1;
        // save+restore together cancel out: no move, no trap, plain write
        save_only = save & ~restore;
        rest_only = restore & ~save;
        ovf       = save_only & wim_q[tgt_save];
        unf       = rest_only & wim_q[tgt_rest];
        cwp_d     = cwp_q;
        if (save_only && !ovf) cwp_d = tgt_save;
        if (rest_only && !unf) cwp_d = tgt_rest;
        // trap check above used the old mask; the new one lands at this edge
        wim_d      = wim_we ? wim_din : wim_q;
        trap_ovf_d = ovf;
        trap_unf_d = unf;
    end

    // Register write resolves rd in the post-move window (add-into-new-window).
    always_comb begin
        wr_en  = we && (rd != 5'd0) && !ovf && !unf;
        wr_idx = phys_idx(rd, cwp_d);
        phys_d = phys_q;
        if (wr_en) phys_d[wr_idx] = wdata;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phys_q     <= '0;
            cwp_q      <= '0;
            wim_q      <= WIM_RST;
            trap_ovf_q <= 1'b0;
            trap_unf_q <= 1'b0;
        end else begin
            phys_q     <= phys_d;
            cwp_q      <= cwp_d;
            wim_q      <= wim_d;
            trap_ovf_q <= trap_ovf_d;
            trap_unf_q <= trap_unf_d;
        end
    end

    assign rdata1   = (rs1 == 5'd0) ? 32'd0 : phys_q[phys_idx(rs1, cwp_q)];
    assign rdata2   = (rs2 == 5'd0) ? 32'd0 : phys_q[phys_idx(rs2, cwp_q)];
    assign cwp      = 5'(cwp_q);
    assign wim      = wim_q;
    assign trap_ovf = trap_ovf_q;
    assign trap_unf = trap_unf_q;

endmodule

// File: tb/tb_sparc_window_regfile.sv
// Directed plus randomized checks of sparc_window_regfile against a
// logical-view model (globals / per-window outs and locals arrays).
module tb_sparc_window_regfile;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs1, rs2, rd;
    logic [31:0]   wdata;
    logic          we, save, restore, wim_we;
    logic [N-1:0]  wim_din;
    logic [31:0]   rdata1, rdata2;
    logic [4:0]    cwp;
    logic [N-1:0]  wim;
    logic          trap_ovf, trap_unf;

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0]  g    [8];
    logic [31:0]  outs [N][8];
    logic [31:0]  locs [N][8];
    int           m_cwp;
    logic [N-1:0] m_wim;
    logic         e_ovf, e_unf;

    sparc_window_regfile #(.NWINDOWS(N)) dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .wdata(wdata),
        .we(we), .save(save), .restore(restore), .wim_we(wim_we), .wim_din(wim_din),
        .rdata1(rdata1), .rdata2(rdata2), .cwp(cwp), .wim(wim),
        .trap_ovf(trap_ovf), .trap_unf(trap_unf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mread(int r, int w);
        if (r == 0)  return 32'd0;
        if (r < 8)   return g[r];
        if (r < 16)  return outs[w][r-8];
        if (r < 24)  return locs[w][r-16];
        return outs[(w+1)%N][r-24];
    endfunction

    task automatic mwrite(int r, int w, logic [31:0] d);
        if (r == 0)       return;
        else if (r < 8)   g[r] = d;
        else if (r < 16)  outs[w][r-8] = d;
        else if (r < 24)  locs[w][r-16] = d;
        else              outs[(w+1)%N][r-24] = d;
    endtask

    task automatic mreset();
        for (int i = 0; i < 8; i++) g[i] = '0;
        for (int w = 0; w < N; w++)
            for (int i = 0; i < 8; i++) begin
                outs[w][i] = '0;
                locs[w][i] = '0;
            end
        m_cwp = 0;
        m_wim = N'(2);
        e_ovf = 1'b0;
        e_unf = 1'b0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = 0; save = 0; restore = 0; wim_we = 0;
        rd = 0; wdata = 0; wim_din = '0;
    endtask

    // One clock: check reads in the current window, clock, update model, check state.
    task automatic step();
        int  ts, tr, ncwp;
        bit  so, ro, ovf, unf;
        #1;
        chk("rdata1", rdata1, mread(int'(rs1), m_cwp));
        chk("rdata2", rdata2, mread(int'(rs2), m_cwp));
        @(posedge clk);
        so  = save && !restore;
        ro  = restore && !save;
        ts  = (m_cwp + N - 1) % N;
        tr  = (m_cwp + 1) % N;
        ovf = so && m_wim[ts];
        unf = ro && m_wim[tr];
        ncwp = m_cwp;
        if (so && !ovf) ncwp = ts;
        if (ro && !unf) ncwp = tr;
        if (we && !ovf && !unf) mwrite(int'(rd), ncwp, wdata);
        m_cwp = ncwp;
        if (wim_we) m_wim = wim_din;
        e_ovf = ovf;
        e_unf = unf;
        #1;
        chk("cwp", 32'(cwp), 32'(m_cwp));
        chk("wim", 32'(wim), 32'(m_wim));
        chk("trap_ovf", 32'(trap_ovf), 32'(e_ovf));
        chk("trap_unf", 32'(trap_unf), 32'(e_unf));
    endtask

    task automatic op(bit w_en, int r, logic [31:0] d, bit sv, bit rs_);
        idle();
        we = w_en; rd = 5'(r); wdata = d; save = sv; restore = rs_;
        step();
        idle();
    endtask

    task automatic peek(int r, logic [31:0] exp, string tag);
        rs1 = 5'(r);
        #1;
        chk(tag, rdata1, exp);
    endtask

    initial begin
        idle();
        rs1 = 0; rs2 = 0;
        reset = 1'b1;
        mreset();
        #12 reset = 1'b0;
        @(posedge clk); #1;

        // reset state
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            chk("rst_rd1", rdata1, 32'd0);
            chk("rst_rd2", rdata2, 32'd0);
        end
        chk("rst_cwp", 32'(cwp), 32'd0);
        chk("rst_wim", 32'(wim), 32'h02);
        chk("rst_traps", {30'd0, trap_ovf, trap_unf}, 32'd0);

        // globals are shared across windows; r0 is hardwired zero
        op(1, 5, 32'hDEADBEEF, 0, 0);
        peek(5, 32'hDEADBEEF, "g5_w0");
        op(0, 0, 0, 1, 0);
        chk("cwp_after_save", 32'(cwp), 32'd7);
        peek(5, 32'hDEADBEEF, "g5_w7");
        op(1, 0, 32'h1234, 0, 0);
        peek(0, 32'd0, "r0_zero");
        op(0, 0, 0, 0, 1);
        chk("cwp_back0", 32'(cwp), 32'd0);

        // outs of window 0 are ins of window 7
        op(1, 8, 32'hA5A5A5A5, 0, 0);
        op(0, 0, 0, 1, 0);
        chk("cwp7", 32'(cwp), 32'd7);
        peek(24, 32'hA5A5A5A5, "ins_w7");
        op(0, 0, 0, 0, 1);
        chk("cwp0", 32'(cwp), 32'd0);
        peek(8, 32'hA5A5A5A5, "outs_w0");

        // six legal saves then overflow
        for (int k = 1; k <= 6; k++) begin
            op(0, 0, 0, 1, 0);
            chk("save_chain_cwp", 32'(cwp), 32'((8 - k) % 8));
            chk("save_chain_ovf", 32'(trap_ovf), 32'd0);
        end
        op(1, 16, 32'h55, 1, 0);
        chk("ovf_pulse", 32'(trap_ovf), 32'd1);
        chk("ovf_cwp", 32'(cwp), 32'd2);
        op(0, 0, 0, 0, 0);
        chk("ovf_clear", 32'(trap_ovf), 32'd0);
        peek(16, 32'd0, "ovf_write_dropped");

        // back to window 0, then underflow with old-wim semantics
        for (int k = 0; k < 6; k++) op(0, 0, 0, 0, 1);
        chk("cwp_ret0", 32'(cwp), 32'd0);
        op(0, 0, 0, 0, 1);
        chk("unf_pulse", 32'(trap_unf), 32'd1);
        chk("unf_cwp", 32'(cwp), 32'd0);
        idle(); restore = 1; wim_we = 1; wim_din = 8'h80;
        step(); idle();
        chk("unf_oldwim", 32'(trap_unf), 32'd1);
        chk("wim_new", 32'(wim), 32'h80);
        op(0, 0, 0, 0, 1);
        chk("rest_ok_cwp", 32'(cwp), 32'd1);
        chk("rest_ok_unf", 32'(trap_unf), 32'd0);

        // write into the new window on SAVE
        op(0, 0, 0, 0, 1);
        op(0, 0, 0, 0, 1);
        chk("cwp3", 32'(cwp), 32'd3);
        op(1, 16, 32'h33, 0, 0);
        op(1, 16, 32'h77, 1, 0);
        chk("cwp2", 32'(cwp), 32'd2);
        peek(16, 32'h77, "loc_w2");
        op(0, 0, 0, 0, 1);
        peek(16, 32'h33, "loc_w3");

        // save+restore together: no move, write in current window
        op(1, 17, 32'hCAFE0001, 1, 1);
        chk("sr_cwp", 32'(cwp), 32'd3);
        peek(17, 32'hCAFE0001, "sr_write");

        // asynchronous reset mid-cycle
        idle(); save = 1; we = 1; rd = 5'd9; wdata = 32'hFFFF;
        #2 reset = 1'b1;
        #1;
        chk("arst_cwp", 32'(cwp), 32'd0);
        chk("arst_wim", 32'(wim), 32'h02);
        rs1 = 5'd16;
        #1;
        chk("arst_data", rdata1, 32'd0);
        mreset();
        reset = 1'b0;
        idle();
        @(posedge clk); #1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            rs1     = 5'($urandom_range(0, 31));
            rs2     = 5'($urandom_range(0, 31));
            rd      = 5'($urandom_range(0, 31));
            wdata   = $urandom;
            we      = ($urandom_range(0, 1) == 1);
            save    = ($urandom_range(0, 3) == 0);
            restore = ($urandom_range(0, 3) == 0);
            wim_we  = ($urandom_range(0, 15) == 0);
            wim_din = N'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
